// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter slice.
// Latency: none, declarations only.
// Backpressure: not applicable.
package vga_fb_pkg;

    localparam int FB_ADDR_W = 19;   // 640x480 = 307200 words fits in 19 bits
    localparam int FB_DATA_W = 16;   // one pixel word
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FB_WORDS  = H_ACTIVE * V_ACTIVE;

    // Owner of an in-flight RAM read; writes travel as TAG_NONE.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    // Host port identity, used for the round-robin pointer.
    typedef enum logic {
        SEL_WRITE = 1'b0,
        SEL_READ  = 1'b1
    } sel_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of display, host and RAM-side signals around the framebuffer arbiter.
// Latency: none, wiring only.
// Backpressure: host ports use valid/ready; display and RAM sides have none.
//   slave  : arbiter view (requests in, grants / RAM controls out)
//   master : environment view (display block, host and RAM model)
interface vga_fb_arbiter_if #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int STALL_W = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_data_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [STALL_W-1:0] host_stall_cnt;

    modport slave (
        input  disp_req, disp_addr,
        output disp_data, disp_data_valid,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_valid, rd_addr,
        output rd_ready, rd_resp_valid, rd_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output host_stall_cnt
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_data, disp_data_valid,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_valid, rd_addr,
        input  rd_ready, rd_resp_valid, rd_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  host_stall_cnt
    );

endinterface

// File: rtl/vga_fb_arbiter_rr_arb2.sv
// Two-requester round-robin picker (host write vs host read) holding rr_last.
// Latency: grants are combinational; rr_last updates on the granting edge.
// Backpressure: en=0 (display owns the slot) drops both readies and grants.
//   ports: clk, rst, en, req_wr/req_rd in; rdy_wr/rdy_rd, gnt_wr/gnt_rd out
module rr_arb2
    import vga_fb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic rdy_wr,
    output logic rdy_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    sel_t rr_last;

    // A ready looks only at the other port's request, so a host can sample
    // ready before deciding to raise its own valid.
    assign rdy_wr = en && (!req_rd || rr_last == SEL_READ);
    assign rdy_rd = en && (!req_wr || rr_last == SEL_WRITE);

    // On a tie exactly one ready is high, so at most one grant fires.
    assign gnt_wr = rdy_wr && req_wr;
    assign gnt_rd = rdy_rd && req_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= SEL_READ;     // write wins the first tie
        end else if (gnt_wr) begin
            rr_last <= SEL_WRITE;
        end else if (gnt_rd) begin
            rr_last <= SEL_READ;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, host write/read share the rest round-robin.
// Latency: RAM controls combinational from grant; read data returns 2 cycles after grant.
// Backpressure: wr_ready/rd_ready low while display or the other host port owns the slot.
//   ports: clk, rst (sync, active high); bus (display, host, RAM, stall counter)
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int DATA_W  = FB_DATA_W,
    parameter int STALL_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    vga_fb_arbiter_if.slave bus
);

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    logic gnt_wr;
    logic gnt_rd;
    logic host_gnt;
    logic host_req;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .en     (!bus.disp_req),
        .req_wr (bus.wr_valid),
        .req_rd (bus.rd_valid),
        .rdy_wr (bus.wr_ready),
        .rdy_rd (bus.rd_ready),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    assign host_gnt = gnt_wr || gnt_rd;
    assign host_req = bus.wr_valid || bus.rd_valid;

    // RAM controls and owner tag for this cycle's slot.
    logic              en_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    tag_t              tag_c;

    always_comb begin
        en_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        tag_c   = TAG_NONE;
        if (bus.disp_req) begin
            en_c   = 1'b1;
            addr_c = bus.disp_addr;
            tag_c  = TAG_DISP;
        end else if (gnt_wr) begin
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = bus.wr_addr;
            wdata_c = bus.wr_data;
        end else if (gnt_rd) begin
            en_c   = 1'b1;
            addr_c = bus.rd_addr;
            tag_c  = TAG_HOST;
        end
    end

    assign bus.mem_en    = en_c;
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;

    // Stage 1 tags the access while the RAM reads; stage 2 captures the
    // RAM output together with its owner.
    tag_t              tag_s1;
    tag_t              tag_s2;
    logic [DATA_W-1:0] data_s2;
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_s1  <= TAG_NONE;
            tag_s2  <= TAG_NONE;
            data_s2 <= '0;
            stall_q <= '0;
        end else begin
            tag_s1  <= tag_c;
            tag_s2  <= tag_s1;
            data_s2 <= (tag_s1 == TAG_NONE) ? '0 : bus.mem_rdata;
            if (!host_req || host_gnt) begin
                stall_q <= '0;
            end else if (stall_q != STALL_MAX) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.disp_data_valid = (tag_s2 == TAG_DISP);
    assign bus.disp_data       = (tag_s2 == TAG_DISP) ? data_s2 : '0;
    assign bus.rd_resp_valid   = (tag_s2 == TAG_HOST);
    assign bus.rd_resp_data    = (tag_s2 == TAG_HOST) ? data_s2 : '0;
    assign bus.host_stall_cnt  = stall_q;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbiter for the single-port pixel framebuffer shared between VGA scan-out and a host (CPU/drawing engine). It sits between the `vga` timing/pixel block and the framebuffer RAM. Display reads are granted unconditionally so scan-out never stalls. Host writes and host reads share the remaining memory slots round-robin, and the block returns read data to the correct owner at a fixed latency.

## Interface
Parameters:
- `ADDR_W`, 19, framebuffer word address width (640×480 = 307200 words).
- `DATA_W`, 16, pixel word width (matches `pixel[15:0]` on `vga`).
- `STALL_W`, 16, width of the host stall counter.

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `disp_req`  in  1  display needs a pixel this cycle (active video plus prefetch).
- `disp_addr`  in  ADDR_W  display pixel address (low bits of `pixel_ADDR`).
- `disp_data`  out  DATA_W  returned pixel.
- `disp_data_valid`  out  1  `disp_data` valid.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  host write accepted when high together with `wr_valid`.
- `wr_addr`  in  ADDR_W  host write address.
- `wr_data`  in  DATA_W  host write data.
- `rd_valid`  in  1  host read request.
- `rd_ready`  out  1  host read accepted when high together with `rd_valid`.
- `rd_addr`  in  ADDR_W  host read address.
- `rd_resp_valid`  out  1  host read data valid.
- `rd_resp_data`  out  DATA_W  host read data.
- `mem_en`  out  1  RAM access enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, 1-cycle synchronous read.
- `host_stall_cnt`  out  STALL_W  consecutive cycles a host request has been pending without a grant; saturating.

## Operation
- Grants are decided each cycle and there is at most one RAM access per cycle. Priority:
  - `disp_req` always wins.
  - Otherwise a host request is granted. If both `wr_valid` and `rd_valid` are high, the round-robin pointer `rr_last` picks the port not granted last.
- `rr_last` updates only on a host grant. Reset value is READ, so WRITE wins the first tie.
- `wr_ready` = !`disp_req` && (!`rd_valid` || `rr_last`==READ). `rd_ready` is symmetric.
  - Neither ready depends on its own port's valid.
- `mem_*` are combinational from the grant.
  - Display grant: `mem_en`=1, `mem_we`=0, `mem_addr`=`disp_addr`.
  - Write grant: `mem_we`=1, `mem_wdata`=`wr_data`.
  - No grant: `mem_en`=0, and all other `mem_*` outputs are 0.
- Return tracking uses a 2-stage owner-tag pipeline (NONE/DISP/HOST).
  - Stage 1 is tagged at grant.
  - `mem_rdata` is registered in stage 2 and steered to `disp_data` or `rd_resp_data` by tag.
  - Writes carry tag NONE.
- `host_stall_cnt` behaviour:
  - Increments when (`wr_valid` || `rd_valid`) and there is no host grant.
  - Clears to 0 on any host grant, or when no host request is pending.
  - Saturates at all-ones.
- A write and a read to the same address pending together are ordered only by round-robin. The host must serialize if it needs read-after-write ordering.

## Timing
- Reset values:
  - All outputs 0, except the ready outputs, which follow their combinational equations.
  - Tag pipeline cleared to NONE. `rr_last`=READ. Stall counter 0.
- Reset mid-operation: in-flight reads are discarded. No `*_valid` pulse appears after reset is asserted.
- Read latency: a request granted in cycle N drives `disp_data_valid`/`rd_resp_valid` high in cycle N+2 for exactly 1 cycle.
- Back-to-back display reads give one `disp_data_valid` per cycle, in order, at throughput 1.
- Write takes effect at the RAM edge ending the grant cycle. There is no response.
- During continuous `disp_req`, both readies stay 0 and the stall counter runs.

## Structure
- Package `vga_fb_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - H_ACTIVE=640, V_ACTIVE=480.
  - Owner-tag typedef {TAG_NONE, TAG_DISP, TAG_HOST}.
  - Port-select typedef {SEL_WRITE, SEL_READ}.
- Sub-module `rr_arb2`: 2-requester round-robin picker holding `rr_last`, with an enable that forces no grant when the display owns the slot.

## Test plan
- Reset then idle, with `rst` held 3 cycles:
  - All valid outputs are 0, `host_stall_cnt`=0, `mem_en`=0.
  - `wr_ready`=1 and `rd_ready`=1 while no competing request exists.
- Display priority: `disp_req`=1 for 10 cycles at addresses 0..9, `wr_valid`=1 throughout.
  - `wr_ready`=0 for those cycles; `host_stall_cnt` reaches 10.
  - `disp_data` returns RAM[0..9] in cycles 2..11.
  - The write is granted in the first cycle after `disp_req` falls.
- Round-robin: `disp_req`=0, with `wr_valid` and `rd_valid` both held high for 4 cycles.
  - Grants alternate W,R,W,R.
  - Read responses appear 2 cycles after each R grant.
- Write-then-read: write 0xBEEF to address 0x12345, then read 0x12345.
  - `rd_resp_data`=0xBEEF with `rd_resp_valid` exactly 2 cycles after the read grant.
- Mixed returns: alternate display and host reads to different addresses.
  - Each datum goes only to its owner; `disp_data_valid` and `rd_resp_valid` are never high in the same cycle.
- Reset mid-read: assert `rst` the cycle after a read grant.
  - No `rd_resp_valid` pulse follows; all outputs are 0 next cycle.
  - The stall counter saturates correctly when `disp_req` is held for more than 65535 cycles.
